// File: rtl/clkset_pkg.sv
// Shared types and constants for the HH:MM keypad entry sequencer:
// state encoding, per-position digit limits and the commit target encoding.
package clkset_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      E_LH   = 3'd1,
      E_RH   = 3'd2,
      E_LM   = 3'd3,
      E_RM   = 3'd4,
      COMMIT = 3'd5
   } state_t;

   localparam logic [3:0] LH_MAX     = 4'd2;
   localparam logic [3:0] RH_MAX     = 4'd9;
   localparam logic [3:0] RH_MAX_20H = 4'd3;   // hours 20..23 only
   localparam logic [3:0] LM_MAX     = 4'd5;
   localparam logic [3:0] RM_MAX     = 4'd9;

   localparam logic TARGET_TIME  = 1'b0;
   localparam logic TARGET_ALARM = 1'b1;

   // Largest digit allowed at an entry position; RH tightens once LH is 2.
   function automatic logic [3:0] digit_limit(input state_t pos, input logic [3:0] lh);
      logic [3:0] lim;
      lim = 4'd0;
      case (pos)
         E_LH:    lim = LH_MAX;
         E_RH:    lim = (lh == 4'd2) ? RH_MAX_20H : RH_MAX;
         E_LM:    lim = LM_MAX;
         E_RM:    lim = RM_MAX;
         default: lim = 4'd0;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/time_set_sequencer_digit_limit_check.sv
// Combinational keypad digit validator: accepts key_val when it does not
// exceed the limit of the current entry position. Non-entry positions
// never accept, so a stray strobe outside entry cannot store anything.
module digit_limit_check
   import clkset_pkg::*;
(
   input  state_t     pos,
   input  logic [3:0] key_val,
   input  logic [3:0] lh,
   output logic       accept
);

   logic is_entry;

   // Compare against the position limit; values 10..15 exceed every limit.
   always_comb begin
      is_entry = (pos == E_LH) || (pos == E_RH) || (pos == E_LM) || (pos == E_RM);
      accept   = is_entry && (key_val <= digit_limit(pos, lh));
   end

endmodule

// File: rtl/time_set_sequencer.sv
// HH:MM keypad entry sequencer for clock time or alarm.
// Walks LH -> RH -> LM -> RM, validates each digit, then commits all four
// digits at once with a one-cycle commit pulse. All outputs are registered.
// Optional build macro ENTRY_TIMEOUT_EN: abort entry after TIMEOUT_CYCLES
// cycles without a key.
module time_set_sequencer
   import clkset_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_time,
   input  logic        start_alarm,
   input  logic        cancel,
   input  logic        key_valid,
   input  logic [3:0]  key_val,
   output logic        set_lh,
   output logic        set_rh,
   output logic        set_lm,
   output logic        set_rm,
   output logic        busy,
   output logic        key_err,
   output logic        commit,
   output logic        commit_alarm,
   output logic [15:0] digits_out
);

   state_t      state_q, state_d;
   logic [15:0] wbuf_q, wbuf_d;          // working buffer {LH,RH,LM,RM}
   logic        target_q, target_d;
   logic [15:0] digits_q, digits_d;
   logic        commit_q, commit_d;
   logic        commit_alarm_q, commit_alarm_d;
   logic        key_err_q, key_err_d;
   logic [3:0]  set_q, set_d;           // {lh,rh,lm,rm}
   logic        busy_q, busy_d;

   logic        accept;
   logic        in_entry;
   logic        timeout_hit;
   logic        abort;

   digit_limit_check u_limit (
      .pos     (state_q),
      .key_val (key_val),
      .lh      (wbuf_q[15:12]),
      .accept  (accept)
   );

   assign in_entry = (state_q == E_LH) || (state_q == E_RH) ||
                     (state_q == E_LM) || (state_q == E_RM);

`ifdef ENTRY_TIMEOUT_EN
   logic [31:0] idle_cnt_q, idle_cnt_d;

   // Idle counter: restarts on entry and on any key, counts while waiting.
   always_comb begin
      idle_cnt_d = 32'd0;
      if (in_entry && !key_valid)
         idle_cnt_d = idle_cnt_q + 32'd1;
   end

   // Idle counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cnt_q <= 32'd0;
      else     idle_cnt_q <= idle_cnt_d;
   end

   assign timeout_hit = in_entry && (idle_cnt_q == (TIMEOUT_CYCLES - 32'd1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
`endif

   assign abort = in_entry && (cancel || timeout_hit);

   // Next-state and next-output computation; outputs are derived from the
   // next state so they line up with the state they describe.
   always_comb begin
      state_d        = state_q;
      wbuf_d         = wbuf_q;
      target_d       = target_q;
      digits_d       = digits_q;
      commit_d       = 1'b0;
      commit_alarm_d = 1'b0;
      key_err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_time) begin
               state_d  = E_LH;
               target_d = TARGET_TIME;
               wbuf_d   = 16'h0000;
            end else if (start_alarm) begin
               state_d  = E_LH;
               target_d = TARGET_ALARM;
               wbuf_d   = 16'h0000;
            end
         end
         E_LH, E_RH, E_LM, E_RM: begin
            if (abort) begin
               state_d = IDLE;
            end else if (key_valid) begin
               if (accept) begin
                  case (state_q)
                     E_LH: begin
                        wbuf_d[15:12] = key_val;
                        state_d       = E_RH;
                     end
                     E_RH: begin
                        wbuf_d[11:8] = key_val;
                        state_d      = E_LM;
                     end
                     E_LM: begin
                        wbuf_d[7:4] = key_val;
                        state_d     = E_RM;
                     end
                     default: begin
                        // Last digit: publish the full value together with
                        // the commit pulse in the COMMIT cycle.
                        wbuf_d[3:0]    = key_val;
                        state_d        = COMMIT;
                        digits_d       = {wbuf_q[15:4], key_val};
                        commit_d       = 1'b1;
                        commit_alarm_d = target_q;
                     end
                  endcase
               end else begin
                  key_err_d = 1'b1;
               end
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      set_d  = {state_d == E_LH, state_d == E_RH, state_d == E_LM, state_d == E_RM};
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         wbuf_q         <= 16'h0000;
         target_q       <= TARGET_TIME;
         digits_q       <= 16'h0000;
         commit_q       <= 1'b0;
         commit_alarm_q <= 1'b0;
         key_err_q      <= 1'b0;
         set_q          <= 4'b0000;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         wbuf_q         <= wbuf_d;
         target_q       <= target_d;
         digits_q       <= digits_d;
         commit_q       <= commit_d;
         commit_alarm_q <= commit_alarm_d;
         key_err_q      <= key_err_d;
         set_q          <= set_d;
         busy_q         <= busy_d;
      end
   end

   assign set_lh       = set_q[3];
   assign set_rh       = set_q[2];
   assign set_lm       = set_q[1];
   assign set_rm       = set_q[0];
   assign busy         = busy_q;
   assign key_err      = key_err_q;
   assign commit       = commit_q;
   assign commit_alarm = commit_alarm_q;
   assign digits_out   = digits_q;

endmodule
